result_mem_stream: RTL and testbench
====================================

Name: result_mem_stream

Overview:
- Synthesizable, clocked successor to the behavioural result collector for the spiking-conv output stage.
- Accepts result packets {addr, value} from the PE/adder network and applies the firing threshold. Stores residue and spike per output neuron.
- Once a full frame of DEPTH_R*DEPTH_R results has arrived, streams the frame out in address order.
- Optional accumulate mode carries membrane residue across frames (multi-timestep operation).

Parameters:
- WIDTH_DATA, 13, width of value field and stored residue.
- DEPTH_R, 21, output map side; N = DEPTH_R*DEPTH_R entries.
- WIDTH_ADDR, $clog2(DEPTH_R*DEPTH_R), address field width (9 for default).
- WIDTH_PKT, 32, input packet width; requires WIDTH_PKT >= WIDTH_ADDR+WIDTH_DATA.
- THRE, 64, firing threshold (unsigned, WIDTH_DATA bits).
- ACCUM, 0, 0 = overwrite mode; 1 = accumulate incoming value onto stored residue.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  packet valid
- in_ready  out  1  packet accept; transfer when in_valid & in_ready at posedge
- in_pkt  in  WIDTH_PKT  value = [WIDTH_DATA-1:0], addr = [WIDTH_DATA+WIDTH_ADDR-1:WIDTH_DATA], upper bits ignored
- out_valid  out  1  readout entry valid
- out_ready  in  1  readout accept
- out_addr  out  WIDTH_ADDR  entry address
- out_spike  out  1  entry spike
- out_residue  out  WIDTH_DATA  entry residue
- frame_done  out  1  one-cycle pulse after last readout handshake
- spike_count  out  $clog2(N+1)  spikes in last frame; held until next frame_done
- err_addr  out  1  sticky: an accepted packet had addr >= N
- busy  out  1  high in CLEAR and DRAIN

Behaviour:
- Reset values: in_ready=0, out_valid=0, frame_done=0, spike_count=0, err_addr=0, busy=1.
- Reset enters CLEAR. Reset asserted mid-frame or mid-drain aborts the frame; nothing partial is output.
- States and transitions:
  - CLEAR: walk addr 0..N-1, one entry per cycle, writing residue=0 and spike=0. Takes N cycles, then goes to COLLECT.
  - COLLECT: in_ready=1. Each accepted in-range packet performs a single-cycle read-modify-write.
    - sum = (ACCUM ? stored_residue : 0) + value, computed WIDTH_DATA+1 wide.
    - If sum >= THRE: residue = sum - THRE, spike = 1. Else: residue = sum, spike = 0.
    - If residue > 2^WIDTH_DATA-1, saturate to all ones.
    - Back-to-back packets to the same address are applied in order; the second sees the first's result.
    - Out-of-range packet: accepted, memory unchanged, err_addr set, not counted.
    - An in-range accept increments rx_count. When rx_count reaches N, go to DRAIN on the next cycle with rx_count=0. Duplicate addresses count; no distinct-address tracking.
  - DRAIN: in_ready=0. out_valid=1 with rd_addr starting at 0; out_* hold stable while out_valid & !out_ready.
    - On each handshake: accumulate the spike into the internal counter, clear that entry's spike bit (residue kept), rd_addr++.
    - After the handshake at N-1: frame_done=1 for one cycle, spike_count updated, go to COLLECT.
    - out_valid drops the cycle after the last handshake.
- Latency: packet accept to stored value is 1 cycle. Readout entry is presented combinationally from the array (flop array, no RAM read latency).
- In overwrite mode the residue is replaced every frame. In accumulate mode it persists across frames until rst.

Decomposition:
- Shared package snn_pkg:
  - result_pkt_t packed struct {addr, value}
  - localparam N_OUT
  - THRE default
  - state enum {CLEAR, COLLECT, DRAIN}
- One sub-module, threshold_unit: combinational sum/compare/subtract/saturate. Reused by membrane/PE blocks.

Test Plan:
- Reset then idle: in_ready stays 0 for 441 cycles, then 1; busy falls on the same cycle.
- Overwrite mode, 441 packets addr=i, value=i%128: drain gives addr 64 -> spike 1, residue 0; addr 63 -> spike 0, residue 63; addr 127 -> spike 1, residue 63; spike_count=192; frame_done pulses once.
- Out-of-range: packet addr=450 -> err_addr=1, no count. 441 further valid packets are still required before DRAIN starts.
- Backpressure: out_ready toggles 1/0 randomly during drain -> every addr 0..440 appears exactly once, in order, with data stable while stalled.
- ACCUM=1, two frames of value=40 at all addresses: frame1 all spike 0, residue 40; frame2 all spike 1, residue 16, spike_count=441.
- Saturation and reset: ACCUM=1, value=8191 twice at addr 0 (residue 8191 -> saturate) -> residue 8191, spike 1. Then assert rst mid-DRAIN -> out_valid=0 next cycle, CLEAR, and the subsequent frame shows residue 0 baseline.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking-conv output stage.
package snn_pkg;

  localparam int WIDTH_DATA_D = 13;
  localparam int DEPTH_R_D    = 21;
  localparam int N_OUT        = DEPTH_R_D * DEPTH_R_D;
  localparam int WIDTH_ADDR_D = $clog2(N_OUT);
  localparam int WIDTH_PKT_D  = 32;
  localparam int THRE_D       = 64;

  typedef struct packed {
    logic [WIDTH_ADDR_D-1:0] addr;
    logic [WIDTH_DATA_D-1:0] value;
  } result_pkt_t;

  typedef enum logic [1:0] {
    CLEAR,
    COLLECT,
    DRAIN
  } state_t;

endpackage

// File: rtl/result_mem_stream_if.sv
// Packet input stream and readout stream of the result memory.
interface result_mem_stream_if #(
  parameter int WIDTH_PKT  = 32,
  parameter int WIDTH_ADDR = 9,
  parameter int WIDTH_DATA = 13
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH_PKT-1:0]  in_pkt;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH_ADDR-1:0] out_addr;
  logic                  out_spike;
  logic [WIDTH_DATA-1:0] out_residue;

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_addr, out_spike, out_residue
  );

  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_addr, out_spike, out_residue
  );
endinterface

// File: rtl/threshold_unit.sv
// Membrane update: add, fire on threshold, subtract threshold, saturate.
module threshold_unit
  import snn_pkg::*;
#(
  parameter int                    WIDTH_DATA = WIDTH_DATA_D,
  parameter logic [WIDTH_DATA-1:0] THRE       = WIDTH_DATA'(THRE_D)
) (
  input  logic [WIDTH_DATA-1:0] base,
  input  logic [WIDTH_DATA-1:0] value,
  output logic [WIDTH_DATA-1:0] residue,
  output logic                  spike
);
  logic [WIDTH_DATA:0] sum;
  logic [WIDTH_DATA:0] diff;

  always_comb begin
    sum     = {1'b0, base} + {1'b0, value};
    spike   = (sum >= {1'b0, THRE});
    diff    = spike ? (sum - {1'b0, THRE}) : sum;
    residue = diff[WIDTH_DATA] ? '1 : diff[WIDTH_DATA-1:0];
  end
endmodule

// File: rtl/result_mem_stream.sv
// Collects thresholded results per output neuron, then streams the frame in address order.
module result_mem_stream
  import snn_pkg::*;
#(
  parameter int WIDTH_DATA = WIDTH_DATA_D,
  parameter int DEPTH_R    = DEPTH_R_D,
  parameter int WIDTH_ADDR = $clog2(DEPTH_R * DEPTH_R),
  parameter int WIDTH_PKT  = WIDTH_PKT_D,
  parameter int THRE       = THRE_D,
  parameter int ACCUM      = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  result_mem_stream_if.slave                   bus,
  output logic                                 frame_done,
  output logic [$clog2(DEPTH_R*DEPTH_R+1)-1:0] spike_count,
  output logic                                 err_addr,
  output logic                                 busy
);
  localparam int N    = DEPTH_R * DEPTH_R;
  localparam int SC_W = $clog2(N + 1);
  localparam logic [WIDTH_ADDR-1:0] LAST = WIDTH_ADDR'(N - 1);

  state_t                state, state_next;
  logic [WIDTH_ADDR-1:0] addr;      // CLEAR walk pointer, then DRAIN read pointer
  logic [WIDTH_ADDR-1:0] rx_count;
  logic [SC_W-1:0]       spk_acc;
  logic [WIDTH_DATA-1:0] res_mem [N];
  logic [N-1:0]          spk_mem;

  logic [WIDTH_ADDR-1:0] pkt_addr;
  logic [WIDTH_DATA-1:0] pkt_value, base, new_res;
  logic                  new_spk, in_range, accept, drain_hs;

  assign pkt_addr  = bus.in_pkt[WIDTH_DATA+WIDTH_ADDR-1:WIDTH_DATA];
  assign pkt_value = bus.in_pkt[WIDTH_DATA-1:0];
  assign in_range  = (pkt_addr <= LAST);
  assign base      = (ACCUM != 0) ? res_mem[pkt_addr] : '0;

  if (WIDTH_PKT > WIDTH_DATA + WIDTH_ADDR) begin : g_pad
    logic unused_pkt_hi;
    assign unused_pkt_hi = ^bus.in_pkt[WIDTH_PKT-1:WIDTH_DATA+WIDTH_ADDR];
  end

  threshold_unit #(
    .WIDTH_DATA (WIDTH_DATA),
    .THRE       (WIDTH_DATA'(THRE))
  ) u_thr (
    .base    (base),
    .value   (pkt_value),
    .residue (new_res),
    .spike   (new_spk)
  );

  assign bus.out_addr    = addr;
  assign bus.out_spike   = spk_mem[addr];
  assign bus.out_residue = res_mem[addr];

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    accept        = 1'b0;
    drain_hs      = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (addr == LAST) state_next = COLLECT;
      end
      COLLECT: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (accept && in_range && rx_count == LAST) state_next = DRAIN;
      end
      DRAIN: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        drain_hs      = bus.out_ready;
        if (drain_hs && addr == LAST) state_next = COLLECT;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      rx_count    <= '0;
      spk_acc     <= '0;
      spike_count <= '0;
      err_addr    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        CLEAR: addr <= (addr == LAST) ? '0 : addr + 1'b1;
        COLLECT: begin
          if (accept && in_range) rx_count <= (rx_count == LAST) ? '0 : rx_count + 1'b1;
          if (accept && !in_range) err_addr <= 1'b1;
        end
        DRAIN: begin
          if (drain_hs && addr == LAST) begin
            addr        <= '0;
            frame_done  <= 1'b1;
            spike_count <= spk_acc + SC_W'(spk_mem[addr]);
            spk_acc     <= '0;
          end else if (drain_hs) begin
            addr    <= addr + 1'b1;
            spk_acc <= spk_acc + SC_W'(spk_mem[addr]);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset branch; the CLEAR walk zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        CLEAR: begin
          res_mem[addr] <= '0;
          spk_mem[addr] <= 1'b0;
        end
        COLLECT: begin
          if (accept && in_range) begin
            res_mem[pkt_addr] <= new_res;
            spk_mem[pkt_addr] <= new_spk;
          end
        end
        DRAIN: if (drain_hs) spk_mem[addr] <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_result_mem_stream.sv
// Randomized bench for result_mem_stream in overwrite and accumulate modes.
module tb_result_mem_stream;
  import snn_pkg::*;

  localparam int N    = N_OUT;
  localparam int THR  = THRE_D;
  localparam int MAXV = (1 << WIDTH_DATA_D) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit          use_ac = 1'b0;
  logic        in_valid_d = 1'b0;
  logic [31:0] in_pkt_d = '0;
  logic        out_ready_d = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int model_res [N];
  bit model_spk [N];
  bit model_err;
  int obs_res [N];
  bit obs_spk [N];

  result_mem_stream_if #(.WIDTH_PKT(32), .WIDTH_ADDR(9), .WIDTH_DATA(13)) if_ow ();
  result_mem_stream_if #(.WIDTH_PKT(32), .WIDTH_ADDR(9), .WIDTH_DATA(13)) if_ac ();

  logic       fd_ow, fd_ac, err_ow, err_ac, busy_ow, busy_ac;
  logic [8:0] sc_ow, sc_ac;

  assign if_ow.in_valid  = !use_ac && in_valid_d;
  assign if_ac.in_valid  = use_ac && in_valid_d;
  assign if_ow.in_pkt    = in_pkt_d;
  assign if_ac.in_pkt    = in_pkt_d;
  assign if_ow.out_ready = !use_ac && out_ready_d;
  assign if_ac.out_ready = use_ac && out_ready_d;

  result_mem_stream #(.ACCUM(0)) dut_ow (
    .clk(clk), .rst(rst), .bus(if_ow.slave),
    .frame_done(fd_ow), .spike_count(sc_ow), .err_addr(err_ow), .busy(busy_ow)
  );
  result_mem_stream #(.ACCUM(1)) dut_ac (
    .clk(clk), .rst(rst), .bus(if_ac.slave),
    .frame_done(fd_ac), .spike_count(sc_ac), .err_addr(err_ac), .busy(busy_ac)
  );

  wire        m_in_ready  = use_ac ? if_ac.in_ready    : if_ow.in_ready;
  wire        m_out_valid = use_ac ? if_ac.out_valid   : if_ow.out_valid;
  wire [8:0]  m_out_addr  = use_ac ? if_ac.out_addr    : if_ow.out_addr;
  wire        m_out_spike = use_ac ? if_ac.out_spike   : if_ow.out_spike;
  wire [12:0] m_out_res   = use_ac ? if_ac.out_residue : if_ow.out_residue;
  wire        m_fd        = use_ac ? fd_ac   : fd_ow;
  wire [8:0]  m_sc        = use_ac ? sc_ac   : sc_ow;
  wire        m_err       = use_ac ? err_ac  : err_ow;
  wire        m_busy      = use_ac ? busy_ac : busy_ow;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      model_res[i] = 0;
      model_spk[i] = 1'b0;
    end
    model_err = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!m_in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!m_in_ready) begin
      n_checks++;
      $display("FAIL wait_ready: in_ready=%0b after %0d cycles, want 1", m_in_ready, n);
    end
  endtask

  task automatic send(input int a, input int v);
    result_pkt_t p;
    int n = 0;
    int s;
    p.addr     = WIDTH_ADDR_D'(a);
    p.value    = WIDTH_DATA_D'(v);
    in_pkt_d   = {10'($urandom), p};
    in_valid_d = 1'b1;
    while (!m_in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!m_in_ready) begin
      n_checks++;
      $display("FAIL send_timeout addr=%0d: in_ready=0, want 1", a);
      in_valid_d = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid_d = 1'b0;
    if (a >= N) begin
      model_err = 1'b1;
    end else begin
      s = (use_ac ? model_res[a] : 0) + v;
      model_spk[a] = (s >= THR);
      if (s >= THR) s -= THR;
      model_res[a] = (s > MAXV) ? MAXV : s;
    end
  endtask

  task automatic drain(input bit bp, input int max_hs);
    int         n_hs = 0;
    int         cyc = 0;
    int         exp_sc = 0;
    bit         stalled = 1'b0;
    logic [8:0]  h_addr;
    logic        h_spk;
    logic [12:0] h_res;
    for (int i = 0; i < N; i++) exp_sc += int'(model_spk[i]);
    while (!m_out_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    while (n_hs < max_hs && cyc < 20000) begin
      if (m_out_valid) begin
        if (stalled) begin
          n_checks++;
          if ({m_out_addr, m_out_spike, m_out_res} !== {h_addr, h_spk, h_res})
            $display("FAIL stall_hold: got addr=%0d spike=%0b res=%0d, want addr=%0d spike=%0b res=%0d",
                     m_out_addr, m_out_spike, m_out_res, h_addr, h_spk, h_res);
          else n_pass++;
        end
        out_ready_d = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready_d) begin
          n_checks++;
          if (m_out_addr !== 9'(n_hs) || m_out_spike !== model_spk[n_hs] ||
              int'(m_out_res) !== model_res[n_hs])
            $display("FAIL entry_%0d: got addr=%0d spike=%0b res=%0d, want addr=%0d spike=%0b res=%0d",
                     n_hs, m_out_addr, m_out_spike, m_out_res, n_hs, model_spk[n_hs], model_res[n_hs]);
          else n_pass++;
          obs_spk[n_hs]   = m_out_spike;
          obs_res[n_hs]   = int'(m_out_res);
          model_spk[n_hs] = 1'b0;
          n_hs++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          h_addr  = m_out_addr;
          h_spk   = m_out_spike;
          h_res   = m_out_res;
        end
      end else begin
        out_ready_d = 1'b0;
        stalled     = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready_d = 1'b0;
    if (n_hs < max_hs) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d handshakes, want %0d", n_hs, max_hs);
    end
    if (max_hs == N) begin
      n_checks++;
      if (m_fd !== 1'b1 || m_out_valid !== 1'b0 || m_sc !== 9'(exp_sc))
        $display("FAIL frame_end: got frame_done=%0b out_valid=%0b spike_count=%0d, want 1 0 %0d",
                 m_fd, m_out_valid, m_sc, exp_sc);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (m_fd !== 1'b0) $display("FAIL frame_done_pulse: got %0b, want 0", m_fd);
      else n_pass++;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    in_valid_d  = 1'b0;
    out_ready_d = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_ready();
  endtask

  task automatic test_reset();
    int  cnt = 0;
    bit  busy_ok = 1'b1;
    use_ac = 1'b0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m_in_ready, m_out_valid, m_fd, m_sc, m_err, m_busy} !== {1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b1})
      $display("FAIL reset_values: got in_ready=%0b out_valid=%0b frame_done=%0b spike_count=%0d err=%0b busy=%0b, want 0 0 0 0 0 1",
               m_in_ready, m_out_valid, m_fd, m_sc, m_err, m_busy);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    while (!m_in_ready && cnt < 1000) begin
      if (m_busy !== 1'b1) busy_ok = 1'b0;
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != N) $display("FAIL clear_length: got %0d cycles with in_ready=0, want %0d", cnt, N);
    else n_pass++;
    n_checks++;
    if (!busy_ok || m_busy !== 1'b0)
      $display("FAIL clear_busy: got busy_during=%0b busy_after=%0b, want 1 0", busy_ok, m_busy);
    else n_pass++;
  endtask

  task automatic test_overwrite();
    for (int i = 0; i < N; i++) send(i, i % 128);
    drain(1'b0, N);
    n_checks++;
    if (obs_spk[64] !== 1'b1 || obs_res[64] != 0 || obs_spk[63] !== 1'b0 || obs_res[63] != 63 ||
        obs_spk[127] !== 1'b1 || obs_res[127] != 63)
      $display("FAIL overwrite_points: got 64:%0b/%0d 63:%0b/%0d 127:%0b/%0d, want 64:1/0 63:0/63 127:1/63",
               obs_spk[64], obs_res[64], obs_spk[63], obs_res[63], obs_spk[127], obs_res[127]);
    else n_pass++;
    n_checks++;
    if (m_sc !== 9'd192) $display("FAIL overwrite_spike_count: got %0d, want 192", m_sc);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    send(450, 5);
    n_checks++;
    if (m_err !== 1'b1 || !model_err) $display("FAIL err_addr_set: got %0b, want 1", m_err);
    else n_pass++;
    for (int i = 0; i < N - 1; i++) send(i, $urandom_range(0, 127));
    n_checks++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1)
      $display("FAIL oor_not_counted: got out_valid=%0b in_ready=%0b, want 0 1", m_out_valid, m_in_ready);
    else n_pass++;
    send(N - 1, $urandom_range(0, 127));
    drain(1'b0, N);
    n_checks++;
    if (m_err !== 1'b1) $display("FAIL err_addr_sticky: got %0b, want 1", m_err);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) send($urandom_range(0, N - 1), $urandom_range(0, MAXV));
    drain(1'b1, N);
  endtask

  task automatic test_accum();
    bit ok;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) send(i, 40);
      drain(1'b0, N);
      ok = 1'b1;
      for (int i = 0; i < N; i++)
        if (obs_spk[i] !== 1'(f) || obs_res[i] != (f == 0 ? 40 : 16)) ok = 1'b0;
      n_checks++;
      if (!ok || m_sc !== (f == 0 ? 9'd0 : 9'd441))
        $display("FAIL accum_frame%0d: got uniform=%0b spike_count=%0d, want 1 %0d", f, ok, m_sc, f * N);
      else n_pass++;
    end
  endtask

  task automatic test_sat_reset();
    send(0, MAXV);
    send(0, MAXV);
    for (int i = 1; i < N - 1; i++) send(i, $urandom_range(0, 200));
    drain(1'b1, 100);
    n_checks++;
    if (obs_res[0] != MAXV || obs_spk[0] !== 1'b1)
      $display("FAIL saturate: got res=%0d spike=%0b, want %0d 1", obs_res[0], obs_spk[0], MAXV);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_out_valid !== 1'b0 || m_busy !== 1'b1 || m_in_ready !== 1'b0)
      $display("FAIL reset_mid_drain: got out_valid=%0b busy=%0b in_ready=%0b, want 0 1 0",
               m_out_valid, m_busy, m_in_ready);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    wait_ready();
    for (int i = 0; i < N; i++) send(i, 10);
    drain(1'b0, N);
    n_checks++;
    if (obs_res[0] != 10 || obs_res[N-1] != 10 || obs_spk[0] !== 1'b0)
      $display("FAIL post_reset_baseline: got res0=%0d resN=%0d spike0=%0b, want 10 10 0",
               obs_res[0], obs_res[N-1], obs_spk[0]);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_overwrite();
    test_out_of_range();
    test_backpressure();
    use_ac = 1'b1;
    do_reset();
    test_accum();
    test_sat_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
